// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, sync imem interface, stall hold, redirect squash.
// Optional perf counters (fetch_count, stall_count) enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] resp_pc;
  logic [31:0]       hold_instr;

  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] pc_next_seq;

  assign target_aligned = redirect_target & ALIGN_MASK;
  assign pc_next_seq    = pc_reg + PC_STEP;

  // Redirect overrides every state so the wrong-path word never reaches IF/ID.
  always_comb begin
    imem_addr   = pc_reg;
    instr_out   = '0;
    pc_out      = '0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    if (redirect) begin
      imem_addr = target_aligned;
      flush     = 1'b1;
    end else begin
      case (state)
        RUN: begin
          instr_out   = imem_data;
          pc_out      = resp_pc;
          instr_valid = 1'b1;
        end
        STALL: begin
          instr_out   = hold_instr;
          pc_out      = resp_pc;
          instr_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BOOT;
      pc_reg     <= RESET_PC;
      resp_pc    <= '0;
      hold_instr <= '0;
    end else if (redirect) begin
      pc_reg     <= target_aligned + PC_STEP;
      resp_pc    <= target_aligned;
      hold_instr <= '0;
      state      <= RUN;
    end else begin
      case (state)
        BOOT: begin
          pc_reg  <= pc_next_seq;
          resp_pc <= pc_reg;
          state   <= RUN;
        end
        RUN: begin
          // Memory keeps re-reading pc_reg while stalled; the displayed word is latched here.
          if (stall) begin
            hold_instr <= imem_data;
            state      <= STALL;
          end else begin
            pc_reg  <= pc_next_seq;
            resp_pc <= pc_reg;
          end
        end
        STALL: begin
          if (!stall) begin
            pc_reg  <= pc_next_seq;
            resp_pc <= pc_reg;
            state   <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_valid && !stall) fetch_count <= fetch_count + 32'd1;
      if (stall && (state != BOOT)) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed plus random bench for instruction_fetch with a delivery-level model.
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic [31:0] imem_data;
  logic [63:0] imem_addr;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int compared = 0;
  int mismatched = 0;

  // Model: either in the boot bubble or "showing" m_pc; counters as plain tallies.
  logic        m_boot = 1'b1;
  logic [63:0] m_pc = '0;
  logic [31:0] m_fc = '0;
  logic [31:0] m_sc = '0;

  logic        obs_valid, obs_flush;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;
  logic [31:0] obs_fc, obs_sc;

  instruction_fetch #(
    .ADDR_W  (64),
    .RESET_PC(RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .flush          (flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (n) @(posedge clk);
    m_boot = 1'b1;
    m_pc = RST_PC;
    m_fc = '0;
    m_sc = '0;
    #1 reset = 1'b1;
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [63:0] tgt);
    logic        ev, ef;
    logic [63:0] ea;
    logic [31:0] ei;
    stall = st;
    redirect = rd;
    redirect_target = tgt;
    @(negedge clk);
    if (rd) begin
      ev = 1'b0; ef = 1'b1; ea = tgt & ~64'd3; ei = '0;
    end else if (m_boot) begin
      ev = 1'b0; ef = 1'b0; ea = RST_PC; ei = '0;
    end else begin
      ev = 1'b1; ef = 1'b0; ea = m_pc + 64'd4; ei = mem_word(m_pc);
    end
    obs_valid = instr_valid;
    obs_flush = flush;
    obs_addr  = imem_addr;
    obs_pc    = pc_out;
    obs_instr = instr_out;
    chk("instr_valid", 64'(instr_valid), 64'(ev));
    chk("flush", 64'(flush), 64'(ef));
    chk("imem_addr", imem_addr, ea);
    chk("instr_out", 64'(instr_out), 64'(ei));
    if (ev) chk("pc_out", pc_out, m_pc);
`ifdef FETCH_PERF_CNT_EN
    obs_fc = fetch_count;
    obs_sc = stall_count;
    chk("fetch_count", 64'(fetch_count), 64'(m_fc));
    chk("stall_count", 64'(stall_count), 64'(m_sc));
`else
    obs_fc = '0;
    obs_sc = '0;
`endif
    @(posedge clk);
    if (ev && !st) m_fc = m_fc + 32'd1;
    if (st && !m_boot) m_sc = m_sc + 32'd1;
    if (rd) m_pc = tgt & ~64'd3;
    else if (m_boot) m_pc = RST_PC;
    else if (!st) m_pc = m_pc + 64'd4;
    m_boot = 1'b0;
    #1;
  endtask

  initial begin
    // Reset and boot
    do_reset(2);
    cycle(0, 0, '0);
    chk("boot_addr", obs_addr, 64'h100);
    chk("boot_valid", 64'(obs_valid), 64'd0);
    cycle(0, 0, '0);
    chk("first_pc", obs_pc, 64'h100);
    chk("first_instr", 64'(obs_instr), 64'(mem_word(64'h100)));
    cycle(0, 0, '0);
    chk("second_pc", obs_pc, 64'h104);

    // Stall hold: 3 stalled cycles plus the release cycle show 0x108
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, '0);
      chk("stall_pc", obs_pc, 64'h108);
      chk("stall_addr", obs_addr, 64'h10C);
      chk("stall_instr", 64'(obs_instr), 64'(mem_word(64'h108)));
    end
    cycle(0, 0, '0);
    chk("release_pc", obs_pc, 64'h108);
    chk("release_addr", obs_addr, 64'h10C);
    cycle(0, 0, '0);
    chk("after_stall_pc", obs_pc, 64'h10C);
    chk("after_stall_instr", 64'(obs_instr), 64'(mem_word(64'h10C)));

    // Redirect with misaligned target
    cycle(0, 1, 64'h2003);
    chk("redir_flush", 64'(obs_flush), 64'd1);
    chk("redir_valid", 64'(obs_valid), 64'd0);
    chk("redir_addr", obs_addr, 64'h2000);
    cycle(0, 0, '0);
    chk("redir_pc", obs_pc, 64'h2000);
    chk("redir_valid_next", 64'(obs_valid), 64'd1);

    // Stall then stall+redirect while in STALL
    cycle(1, 0, '0);
    cycle(1, 1, 64'h40);
    chk("sr_flush", 64'(obs_flush), 64'd1);
    chk("sr_instr", 64'(obs_instr), 64'd0);
    cycle(0, 0, '0);
    chk("sr_pc", obs_pc, 64'h40);
    chk("sr_instr_next", 64'(obs_instr), 64'(mem_word(64'h40)));

    // Wrap-around
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 0, '0);
    chk("wrap_top_pc", obs_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 0, '0);
    chk("wrap_zero_pc", obs_pc, 64'h0);

    // Reset mid-stall, then counter scenario
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    do_reset(1);
    cycle(0, 0, '0);
    chk("rst_mid_stall_valid", 64'(obs_valid), 64'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 0, '0);
    cycle(0, 0, '0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", 64'(obs_fc), 64'd10);
    chk("perf_stall", 64'(obs_sc), 64'd3);
    do_reset(1);
    cycle(0, 0, '0);
    chk("perf_fetch_rst", 64'(obs_fc), 64'd0);
    chk("perf_stall_rst", 64'(obs_sc), 64'd0);
`endif

    // Random mix of stalls, redirects, near-wrap targets and occasional resets
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [63:0] tgt;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        if ($urandom_range(0, 3) == 0)
          tgt = {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)};
        else
          tgt = {32'($urandom), 32'($urandom)};
        cycle(logic'($urandom_range(0, 99) < 30), logic'($urandom_range(0, 99) < 10), tgt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
